// File: rtl/divisor_secuencial.sv
// Sequential 4-bit / 2-bit restoring divider with ALU flags.
// Optional DIV_EARLY_EXIT_EN resolves trivial divisions directly from IDLE.
module divisor_secuencial (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [1:0] A,
   input  logic [3:0] B,
   output logic [3:0] Q,
   output logic [1:0] R,
   output logic       busy,
   output logic       done,
   output logic       Z,
   output logic       N,
   output logic       C,
   output logic       V
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t     state, state_n;
   logic [1:0] aq;
   logic [3:0] bq;
   logic [1:0] cnt;
   logic [2:0] r;
   logic [3:0] qacc;
   logic [2:0] p;
   logic [2:0] r_n;
   logic       qbit;
   logic       ld;
   logic       go;
   logic [3:0] q_ld;
   logic [1:0] r_ld;
   logic       v_ld;

   always_comb begin
      p    = 3'({r, bq[cnt]});
      qbit = (p >= {1'b0, aq});
      r_n  = qbit ? (p - {1'b0, aq}) : p;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      ld      = 1'b0;
      go      = 1'b0;
      q_ld    = qacc;
      r_ld    = r[1:0];
      v_ld    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
`ifdef DIV_EARLY_EXIT_EN
               if (A == 2'd0) begin
                  state_n = DONE;
                  ld      = 1'b1;
                  q_ld    = 4'hF;
                  r_ld    = B[1:0];
                  v_ld    = 1'b1;
               end else if (A == 2'd1) begin
                  state_n = DONE;
                  ld      = 1'b1;
                  q_ld    = B;
                  r_ld    = 2'd0;
               end else if ({2'b00, A} > B) begin
                  state_n = DONE;
                  ld      = 1'b1;
                  q_ld    = 4'd0;
                  r_ld    = B[1:0];
               end else begin
                  state_n = RUN;
                  go      = 1'b1;
               end
`else
               state_n = RUN;
               go      = 1'b1;
`endif
            end
         end
         RUN: begin
            if (cnt == 2'd0) begin
               state_n = DONE;
               ld      = 1'b1;
               // divide by zero overrides the restoring datapath
               if (aq == 2'd0) begin
                  q_ld = 4'hF;
                  r_ld = bq[1:0];
                  v_ld = 1'b1;
               end else begin
                  q_ld = {qacc[2:0], qbit};
                  r_ld = r_n[1:0];
               end
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aq   <= '0;
         bq   <= '0;
         cnt  <= '0;
         r    <= '0;
         qacc <= '0;
         Q    <= '0;
         R    <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         Z    <= 1'b0;
         N    <= 1'b0;
         C    <= 1'b0;
         V    <= 1'b0;
      end else begin
         done <= ld;
         if (go) begin
            aq   <= A;
            bq   <= B;
            cnt  <= 2'd3;
            r    <= '0;
            qacc <= '0;
            busy <= 1'b1;
         end
         if (state == RUN) begin
            cnt  <= cnt - 2'd1;
            r    <= r_n;
            qacc <= {qacc[2:0], qbit};
         end
         if (ld) begin
            busy <= 1'b0;
            Q    <= q_ld;
            R    <= r_ld;
            Z    <= (q_ld == 4'd0);
            N    <= q_ld[3];
            C    <= (r_ld != 2'd0);
            V    <= v_ld;
         end
      end
   end

endmodule

// File: tb/tb_divisor_secuencial.sv
// Bench for divisor_secuencial: directed plan plus random operations
// checked against an arithmetic reference model.
module tb_divisor_secuencial;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [1:0] A;
   logic [3:0] B;
   logic [3:0] Q;
   logic [1:0] R;
   logic       busy, done, Z, N, C, V;

   int         passed = 0;
   int         failed = 0;
   int         total  = 0;
   logic [9:0] held;
   bit         early_en;

   divisor_secuencial dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
      .Q(Q), .R(R), .busy(busy), .done(done),
      .Z(Z), .N(N), .C(C), .V(V)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [11:0] obs,
                      input logic [11:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {Q,R,Z,N,C,V} from plain integer division
   function automatic logic [9:0] model(input logic [1:0] a,
                                        input logic [3:0] b);
      int q, r;
      if (a == 0) begin
         q = 15;
         r = b % 4;
      end else begin
         q = b / a;
         r = b % a;
      end
      return {4'(q), 2'(r), logic'(q == 0), logic'(q >= 8),
              logic'(r != 0), logic'(a == 0)};
   endfunction

   task automatic run(input logic [1:0] a, input logic [3:0] b,
                      input bit restart);
      logic [9:0] exp;
      int         lat;
      exp = model(a, b);
      lat = (early_en && (a <= 1 || b < a)) ? 1 : 5;
      A = a;
      B = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      A = 2'($urandom);
      B = 4'($urandom);
      for (int k = 1; k <= lat + 1; k++) begin
         @(negedge clk);
         if (restart && k == 2) begin
            start = 1'b1;
            A = 2'd1;
            B = 4'd1;
         end
         if (restart && k == 3) start = 1'b0;
         chk($sformatf("busy a=%0d b=%0d k=%0d", a, b, k),
             12'(busy), 12'(lat == 5 && k <= 4));
         chk($sformatf("done a=%0d b=%0d k=%0d", a, b, k),
             12'(done), 12'(k == lat));
         chk($sformatf("result a=%0d b=%0d k=%0d", a, b, k),
             12'({Q, R, Z, N, C, V}), 12'(k == lat ? exp : held));
         if (k == lat) held = exp;
      end
   endtask

   initial begin
      early_en = 1'b0;
`ifdef DIV_EARLY_EXIT_EN
      early_en = 1'b1;
`endif
      rst_n = 1'b0;
      start = 1'b0;
      A     = '0;
      B     = '0;
      held  = '0;
      #2;
      chk("reset", {Q, R, busy, done, Z, N, C, V}, 12'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run(2'd3, 4'd13, 1'b0);
      run(2'd1, 4'd15, 1'b0);
      run(2'd0, 4'd7, 1'b0);
      run(2'd0, 4'd4, 1'b0);
      run(2'd3, 4'd2, 1'b0);
      run(2'd2, 4'd12, 1'b0);
      repeat (3) begin
         @(negedge clk);
         chk("idle hold", 12'({Q, R, Z, N, C, V, busy, done}),
             12'({held, 2'b00}));
      end
      run(2'd2, 4'd9, 1'b1);

      A = 2'd3;
      B = 4'd11;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort outputs", {Q, R, busy, done, Z, N, C, V}, 12'd0);
      held = '0;
      repeat (2) begin
         @(negedge clk);
         chk("abort no done", 12'({done, busy}), 12'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("post reset idle", 12'({done, busy}), 12'd0);
      run(2'd3, 4'd11, 1'b0);

      repeat (24) run(2'($urandom), 4'($urandom), 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/divisor_secuencial.md
# divisor_secuencial

Sequential restoring divider, the inverse counterpart of the 2-bit × 4-bit circular multiplier in the ALU datapath. Divides a 4-bit unsigned dividend by a 2-bit unsigned divisor, one quotient bit per clock. Produces a 4-bit quotient, a 2-bit remainder and the ALU flag set (Z, N, C, V). A start/busy/done handshake lets the ALU control FSM launch an operation and wait for it to finish.

## Interface
- No parameters; widths fixed by the ALU datapath.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  launch request, sampled in IDLE only
- A  input  2  divisor, unsigned
- B  input  4  dividend, unsigned
- Q  output  4  quotient, registered
- R  output  2  remainder, registered
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when Q/R/flags update
- Z  output  1  zero flag: Q == 0
- N  output  1  negative flag: Q[3]
- C  output  1  remainder flag: R != 0
- V  output  1  overflow flag: divide by zero

## Operation
- Reset, asynchronous on rst_n low: state IDLE; Q, R, busy, done, Z, N, C, V all 0; internal counter and partial remainder 0.
- FSM states are IDLE, RUN and DONE.
- IDLE with start=1: capture A and B into internal registers. busy goes to 1 and the FSM enters RUN with the bit counter at 3.
- RUN performs one restoring step per cycle for counter = 3 down to 0:
  - p = {r[1:0], Bq[counter]}, where p is 3 bits.
  - If p ≥ {1'b0, Aq}: quotient bit = 1 and r = p − Aq. Otherwise quotient bit = 0 and r = p.
  - The partial remainder r is 3 bits internally. Its final value is < Aq, so it fits in R[1:0].
- After the counter-0 step the FSM enters DONE. In DONE, Q, R and the flags are loaded, done=1, busy=0, and the FSM returns to IDLE the next cycle.
- Divide by zero (Aq == 0) gives the forced result Q = 4'hF, R = Bq[1:0], V = 1, regardless of the RUN datapath. All other results have V = 0.
- Q, R and the flags hold their last values until the next DONE. They do not change during RUN.
- start while busy, or in DONE, is ignored and not queued.
- A and B may change freely after the start cycle; only the captured copies are used.
- rst_n low mid-operation aborts immediately and returns all outputs to their reset values. No done pulse is issued.

## Timing
- Start sampled at edge of cycle t.
- busy = 1 during cycles t+1 … t+4 (RUN).
- done = 1 and results valid in cycle t+5 (DONE). busy = 0 in that cycle.
- A new start is accepted at the earliest in cycle t+6 (IDLE). Throughput is one operation per 6 cycles.
- Early-exit path (see Configuration): done and results in cycle t+1, with no RUN cycles. The next start is accepted in t+2.

## Configuration
- DIV_EARLY_EXIT_EN defined:
  - IDLE with start checks the trivial cases and jumps directly to DONE, loading results in the next cycle.
  - Trivial cases: A == 0 gives the divide-by-zero result. A == 1 gives Q = B, R = 0. B < A gives Q = 0, R = B[1:0].
  - busy is never asserted on the early-exit path.
- DIV_EARLY_EXIT_EN undefined: every operation, including divide by zero, takes the full RUN path with 5-cycle latency. Results are identical to the early-exit case.

## Test plan
- B=13, A=3, start at t: done only in t+5 (no macro) with Q=4, R=1, Z=0, N=0, C=1, V=0. busy high in t+1…t+4.
- B=15, A=1: Q=15, R=0, N=1, C=0, Z=0. With macro, done at t+1 and busy never high; without macro, done at t+5.
- B=7, A=0: Q=4'hF, R=3, V=1, N=1. Repeat with B=4, A=0: R=0, C=0.
- B=2, A=3: Q=0, R=2, Z=1, C=1. Then B=12, A=2: Q=6, R=0, Z=0, C=0. Check results held between operations.
- Start B=9, A=2; in t+2 apply start again with B=1, A=1: second start ignored. Result Q=4, R=1, done at t+5 only.
- Start B=11, A=3; pull rst_n low in t+2: all outputs 0 immediately and no done. After release, start B=11, A=3 completes with Q=3, R=2.
